// File: rtl/tdc_measure_sequencer.sv
// Measurement sequencer for the delay-line TDC: arms the core, tracks busy with a timeout,
// lets results settle and hands them out on a valid/ready port. Optional macro: TDC_SEQ_STATS_EN.
module tdc_measure_sequencer #(
    parameter int TO_W          = 16,
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             sampling_clk,
    input  logic             reset_internal_logic,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [TO_W-1:0]  cfg_timeout,
    input  logic             tdc_busy,
    input  logic [31:0]      tdc_coarse,
    input  logic [8:0]       tdc_fine,
    output logic             tdc_arm,
    output logic             tdc_abort,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [31:0]      meas_coarse,
    output logic [8:0]       meas_fine,
    output logic             meas_timeout,
    output logic [CNT_W-1:0] meas_index,
    output logic             run_active,
    output logic             run_done
`ifdef TDC_SEQ_STATS_EN
    ,
    output logic [31:0]      stat_min_coarse,
    output logic [31:0]      stat_max_coarse,
    output logic [CNT_W-1:0] stat_timeouts
`endif
);

    localparam int ST_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_WAIT_START, S_MEASURE, S_SETTLE, S_TIMEOUT, S_OUTPUT, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             busy_meta_q, busy_s_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TO_W-1:0]  to_lim_q, to_lim_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [ST_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0] index_q, index_d;
    logic             abort_seen_q, abort_seen_d;
    logic             arm_q, arm_d;
    logic             abort_q, abort_d;
    logic             valid_q, valid_d;
    logic [31:0]      coarse_q, coarse_d;
    logic [8:0]       fine_q, fine_d;
    logic             to_flag_q, to_flag_d;
    logic             active_q, active_d;
    logic             done_q, done_d;
`ifdef TDC_SEQ_STATS_EN
    logic [31:0]      stat_min_q, stat_min_d;
    logic [31:0]      stat_max_q, stat_max_d;
    logic [CNT_W-1:0] stat_to_q, stat_to_d;
`endif

    logic             to_hit_s;
    logic [TO_W-1:0]  to_inc_s;
    logic [CNT_W-1:0] idx_inc_s;
    logic             last_s;

    // A zero limit disables the timeout; the counter saturates rather than wrapping.
    assign to_hit_s  = (to_lim_q != {TO_W{1'b0}}) && (to_cnt_q == to_lim_q);
    assign to_inc_s  = (to_cnt_q == {TO_W{1'b1}}) ? to_cnt_q : to_cnt_q + TO_W'(1'b1);
    assign idx_inc_s = index_q + CNT_W'(1'b1);
    assign last_s    = (count_q != {CNT_W{1'b0}}) && (idx_inc_s == count_q);

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        to_lim_d     = to_lim_q;
        to_cnt_d     = to_cnt_q;
        settle_cnt_d = settle_cnt_q;
        index_d      = index_q;
        abort_seen_d = (state_q == S_IDLE) ? abort_seen_q : (abort_seen_q | cfg_abort);
        valid_d      = valid_q;
        coarse_d     = coarse_q;
        fine_d       = fine_q;
        to_flag_d    = to_flag_q;
`ifdef TDC_SEQ_STATS_EN
        stat_min_d   = stat_min_q;
        stat_max_d   = stat_max_q;
        stat_to_d    = stat_to_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cfg_start && !cfg_abort) begin
                    count_d      = cfg_count;
                    to_lim_d     = cfg_timeout;
                    index_d      = {CNT_W{1'b0}};
                    abort_seen_d = 1'b0;
`ifdef TDC_SEQ_STATS_EN
                    stat_min_d   = 32'hFFFF_FFFF;
                    stat_max_d   = 32'h0000_0000;
                    stat_to_d    = {CNT_W{1'b0}};
`endif
                    state_d      = S_ARM;
                end else begin
                    state_d      = S_IDLE;
                end
            end
            S_ARM: begin
                to_cnt_d = {TO_W{1'b0}};
                if (cfg_abort) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                to_cnt_d = to_inc_s;
                // Timeout outranks a simultaneous busy rise.
                if (cfg_abort) begin
                    state_d = S_DONE;
                end else if (to_hit_s) begin
                    state_d = S_TIMEOUT;
                end else if (busy_s_q) begin
                    state_d = S_MEASURE;
                end else begin
                    state_d = S_WAIT_START;
                end
            end
            S_MEASURE: begin
                to_cnt_d = to_inc_s;
                if (to_hit_s) begin
                    state_d = S_TIMEOUT;
                end else if (!busy_s_q) begin
                    settle_cnt_d = {ST_W{1'b0}};
                    state_d      = S_SETTLE;
                end else begin
                    state_d = S_MEASURE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q == ST_W'(SETTLE_CYCLES - 1)) begin
                    coarse_d  = tdc_coarse;
                    fine_d    = tdc_fine;
                    to_flag_d = 1'b0;
                    valid_d   = 1'b1;
`ifdef TDC_SEQ_STATS_EN
                    if (tdc_coarse < stat_min_q) begin
                        stat_min_d = tdc_coarse;
                    end else begin
                        stat_min_d = stat_min_q;
                    end
                    if (tdc_coarse > stat_max_q) begin
                        stat_max_d = tdc_coarse;
                    end else begin
                        stat_max_d = stat_max_q;
                    end
`endif
                    state_d   = S_OUTPUT;
                end else begin
                    settle_cnt_d = settle_cnt_q + ST_W'(1'b1);
                end
            end
            S_TIMEOUT: begin
                coarse_d  = 32'h0000_0000;
                fine_d    = 9'h000;
                to_flag_d = 1'b1;
                valid_d   = 1'b1;
`ifdef TDC_SEQ_STATS_EN
                if (stat_to_q != {CNT_W{1'b1}}) begin
                    stat_to_d = stat_to_q + CNT_W'(1'b1);
                end else begin
                    stat_to_d = stat_to_q;
                end
`endif
                state_d   = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (meas_ready) begin
                    valid_d = 1'b0;
                    if (last_s || abort_seen_q || cfg_abort) begin
                        state_d = S_DONE;
                    end else begin
                        index_d = idx_inc_s;
                        state_d = S_ARM;
                    end
                end else begin
                    state_d = S_OUTPUT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        arm_d    = (state_d == S_ARM) || (state_d == S_WAIT_START);
        abort_d  = (state_d == S_TIMEOUT);
        active_d = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
    end

    // State, synchroniser and output registers.
    always_ff @(posedge sampling_clk or negedge reset_internal_logic) begin
        if (!reset_internal_logic) begin
            state_q      <= S_IDLE;
            busy_meta_q  <= 1'b0;
            busy_s_q     <= 1'b0;
            count_q      <= {CNT_W{1'b0}};
            to_lim_q     <= {TO_W{1'b0}};
            to_cnt_q     <= {TO_W{1'b0}};
            settle_cnt_q <= {ST_W{1'b0}};
            index_q      <= {CNT_W{1'b0}};
            abort_seen_q <= 1'b0;
            arm_q        <= 1'b0;
            abort_q      <= 1'b0;
            valid_q      <= 1'b0;
            coarse_q     <= 32'h0000_0000;
            fine_q       <= 9'h000;
            to_flag_q    <= 1'b0;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
`ifdef TDC_SEQ_STATS_EN
            stat_min_q   <= 32'h0000_0000;
            stat_max_q   <= 32'h0000_0000;
            stat_to_q    <= {CNT_W{1'b0}};
`endif
        end else begin
            state_q      <= state_d;
            busy_meta_q  <= tdc_busy;
            busy_s_q     <= busy_meta_q;
            count_q      <= count_d;
            to_lim_q     <= to_lim_d;
            to_cnt_q     <= to_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            index_q      <= index_d;
            abort_seen_q <= abort_seen_d;
            arm_q        <= arm_d;
            abort_q      <= abort_d;
            valid_q      <= valid_d;
            coarse_q     <= coarse_d;
            fine_q       <= fine_d;
            to_flag_q    <= to_flag_d;
            active_q     <= active_d;
            done_q       <= done_d;
`ifdef TDC_SEQ_STATS_EN
            stat_min_q   <= stat_min_d;
            stat_max_q   <= stat_max_d;
            stat_to_q    <= stat_to_d;
`endif
        end
    end

    assign tdc_arm      = arm_q;
    assign tdc_abort    = abort_q;
    assign meas_valid   = valid_q;
    assign meas_coarse  = coarse_q;
    assign meas_fine    = fine_q;
    assign meas_timeout = to_flag_q;
    assign meas_index   = index_q;
    assign run_active   = active_q;
    assign run_done     = done_q;
`ifdef TDC_SEQ_STATS_EN
    assign stat_min_coarse = stat_min_q;
    assign stat_max_coarse = stat_max_q;
    assign stat_timeouts   = stat_to_q;
`endif

endmodule

// File: tb/tb_tdc_measure_sequencer.sv
// Bench for tdc_measure_sequencer: table of TDC results, behavioural TDC driver and a
// scoreboard of expected entries compared at every valid/ready handshake.
module tb_tdc_measure_sequencer;

    localparam int CNT_W = 16;
    localparam int TO_W  = 16;

    logic             sampling_clk = 1'b0;
    logic             reset_internal_logic = 1'b1;
    logic             cfg_start = 1'b0;
    logic             cfg_abort = 1'b0;
    logic [CNT_W-1:0] cfg_count = '0;
    logic [TO_W-1:0]  cfg_timeout = '0;
    logic             tdc_busy = 1'b0;
    logic [31:0]      tdc_coarse = '0;
    logic [8:0]       tdc_fine = '0;
    logic             meas_ready = 1'b0;
    logic             tdc_arm, tdc_abort, meas_valid, meas_timeout, run_active, run_done;
    logic [31:0]      meas_coarse;
    logic [8:0]       meas_fine;
    logic [CNT_W-1:0] meas_index;
`ifdef TDC_SEQ_STATS_EN
    logic [31:0]      stat_min_coarse, stat_max_coarse;
    logic [CNT_W-1:0] stat_timeouts;
`endif

    tdc_measure_sequencer #(.TO_W(TO_W), .CNT_W(CNT_W), .SETTLE_CYCLES(4)) dut (
        .sampling_clk(sampling_clk), .reset_internal_logic(reset_internal_logic),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_count(cfg_count),
        .cfg_timeout(cfg_timeout), .tdc_busy(tdc_busy), .tdc_coarse(tdc_coarse),
        .tdc_fine(tdc_fine), .tdc_arm(tdc_arm), .tdc_abort(tdc_abort),
        .meas_valid(meas_valid), .meas_ready(meas_ready), .meas_coarse(meas_coarse),
        .meas_fine(meas_fine), .meas_timeout(meas_timeout), .meas_index(meas_index),
        .run_active(run_active), .run_done(run_done)
`ifdef TDC_SEQ_STATS_EN
        , .stat_min_coarse(stat_min_coarse), .stat_max_coarse(stat_max_coarse),
        .stat_timeouts(stat_timeouts)
`endif
    );

    always #5 sampling_clk = ~sampling_clk;

    typedef struct {
        logic [31:0] coarse;
        logic [8:0]  fine;
        int          busy_len;
        logic        exp_to;
    } vec_t;

    typedef struct {
        logic [31:0]      coarse;
        logic [8:0]       fine;
        logic             to;
        logic [CNT_W-1:0] idx;
    } ent_t;

    vec_t tbl [7];
    ent_t sb_q [$];

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    int arm_rise_cnt = 0;
    int last_arm_cyc = 0;
    int last_abort_cyc = 0;
    logic arm_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        total_cnt++;
        $display("FAIL %s: wait bound expired before the expected event", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sampling_clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] c, input logic [8:0] f, input logic t,
                            input logic [CNT_W-1:0] i);
        ent_t e;
        e.coarse = c; e.fine = f; e.to = t; e.idx = i;
        sb_q.push_back(e);
    endtask

    task automatic wait_arm(input logic level, input int budget, input string name);
        int n = 0;
        while (tdc_arm !== level && n < budget) begin
            @(negedge sampling_clk);
            n++;
        end
        if (tdc_arm !== level) fail(name);
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (run_done !== 1'b1 && n < budget) begin
            @(negedge sampling_clk);
            n++;
        end
        if (run_done !== 1'b1) fail(name);
        tick(1);
        check({name, "_inactive"}, run_active, 1'b0);
    endtask

    task automatic start_run(input logic [CNT_W-1:0] cnt, input logic [TO_W-1:0] to);
        tick(1);
        cfg_count = cnt; cfg_timeout = to; cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0;
    endtask

    // Behavioural TDC: busy for busy_len cycles after the arm (0 = never starts).
    task automatic run_measure(input logic [31:0] c, input logic [8:0] f, input int busy_len,
                               input int abort_at);
        wait_arm(1'b1, 300, "arm_rise");
        tick(1);
        tdc_coarse = c; tdc_fine = f;
        if (busy_len > 0) begin
            tdc_busy = 1'b1;
            for (int i = 0; i < busy_len; i++) begin
                tick(1);
                if (abort_at > 0 && i == abort_at - 1) cfg_abort = 1'b1;
            end
            tdc_busy = 1'b0;
        end
        wait_arm(1'b0, 300, "arm_fall");
    endtask

    // Event monitor and scoreboard comparison at each handshake.
    initial begin
        forever begin
            ent_t e;
            @(negedge sampling_clk);
            cyc++;
            if (reset_internal_logic) begin
                if (tdc_arm && !arm_prev) begin arm_rise_cnt++; last_arm_cyc = cyc; end
                if (tdc_abort) begin abort_cnt++; last_abort_cyc = cyc; end
                if (run_done) done_cnt++;
                if (meas_valid && meas_ready) begin
                    hs_cnt++;
                    if (sb_q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL sb_unexpected: actual=entry idx %0d required=none", meas_index);
                    end else begin
                        e = sb_q.pop_front();
                        check("meas_coarse", meas_coarse, e.coarse);
                        check("meas_fine", meas_fine, e.fine);
                        check("meas_timeout", meas_timeout, e.to);
                        check("meas_index", meas_index, e.idx);
                    end
                end
            end
            arm_prev = tdc_arm;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1);
    end

    initial begin
        int base_hs, base_done, base_abort, base_arm, bad;
        logic [31:0] snap_c;
        logic [8:0]  snap_f;
        logic [CNT_W-1:0] snap_i;

        tbl[0] = '{32'd5,  9'd20, 10, 1'b0};
        tbl[1] = '{32'd6,  9'd21, 10, 1'b0};
        tbl[2] = '{32'd7,  9'd22, 10, 1'b0};
        tbl[3] = '{32'd9,  9'd30, 10, 1'b0};
        tbl[4] = '{32'd3,  9'd31, 10, 1'b0};
        tbl[5] = '{32'd12, 9'd32, 10, 1'b0};
        tbl[6] = '{32'd0,  9'd0,  0,  1'b1};

        #1 reset_internal_logic = 1'b0;
        #12;
        check("reset_outputs", {tdc_arm, tdc_abort, meas_valid, meas_coarse, meas_fine,
              meas_timeout, meas_index, run_active, run_done}, 64'd0);
        tick(1);
        reset_internal_logic = 1'b1;
        tick(2);

        // Asynchronous reset while waiting for busy.
        start_run(16'd1, 16'd0);
        wait_arm(1'b1, 20, "rst_arm");
        tick(3);
        #1 reset_internal_logic = 1'b0;
        #1;
        check("rst_tdc_arm", tdc_arm, 1'b0);
        check("rst_run_active", run_active, 1'b0);
        check("rst_meas_valid", meas_valid, 1'b0);
        tick(2);
        reset_internal_logic = 1'b1;
        tick(2);

        // Three normal measurements.
        meas_ready = 1'b1;
        base_hs = hs_cnt; base_done = done_cnt;
        start_run(16'd3, 16'd100);
        for (int i = 0; i < 3; i++) begin
            push_exp(tbl[i].coarse, tbl[i].fine, tbl[i].exp_to, CNT_W'(i));
            run_measure(tbl[i].coarse, tbl[i].fine, tbl[i].busy_len, 0);
        end
        wait_done(200, "run3_done");
        tick(3);
        check("run3_entries", hs_cnt - base_hs, 3);
        check("run3_done_pulses", done_cnt - base_done, 1);
        check("run3_sb_empty", sb_q.size(), 0);

        // Busy never rises: timeout entry.
        base_abort = abort_cnt; base_hs = hs_cnt;
        start_run(16'd1, 16'd20);
        push_exp(32'd0, 9'd0, 1'b1, '0);
        run_measure(32'hDEAD_BEEF, 9'h1AB, 0, 0);
        wait_done(200, "to_done");
        check("to_abort_pulses", abort_cnt - base_abort, 1);
        check("to_entries", hs_cnt - base_hs, 1);
        if (last_abort_cyc - last_arm_cyc < 19 || last_abort_cyc - last_arm_cyc > 23) begin
            total_cnt++;
            $display("FAIL to_delay: actual=%0d cycles required=19..23", last_abort_cyc - last_arm_cyc);
        end else begin
            total_cnt++; pass_cnt++;
        end

        // Backpressure: outputs hold, no re-arm until the handshake.
        meas_ready = 1'b0;
        start_run(16'd2, 16'd0);
        push_exp(32'h55, 9'h11, 1'b0, '0);
        run_measure(32'h55, 9'h11, 8, 0);
        begin
            int n = 0;
            while (meas_valid !== 1'b1 && n < 50) begin @(negedge sampling_clk); n++; end
            if (meas_valid !== 1'b1) fail("hold_valid");
        end
        tick(1);
        snap_c = meas_coarse; snap_f = meas_fine; snap_i = meas_index;
        bad = 0;
        cfg_start = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            cfg_start = 1'b0;
            tdc_coarse = $urandom; tdc_fine = 9'($urandom);
            if (meas_valid !== 1'b1 || meas_coarse !== snap_c || meas_fine !== snap_f ||
                meas_index !== snap_i || tdc_arm !== 1'b0) bad++;
        end
        check("hold_stable", bad, 0);
        meas_ready = 1'b1;
        tick(1);
        check("arm_after_hs", tdc_arm, 1'b1);
        push_exp(32'h66, 9'h22, 1'b0, 16'd1);
        run_measure(32'h66, 9'h22, 8, 0);
        wait_done(200, "hold_done");

        // Continuous mode, abort during the fourth measurement.
        base_hs = hs_cnt; base_arm = arm_rise_cnt;
        start_run(16'd0, 16'd0);
        for (int i = 0; i < 4; i++) begin
            push_exp(32'h100 + 32'(i), 9'(i + 1), 1'b0, CNT_W'(i));
            run_measure(32'h100 + 32'(i), 9'(i + 1), 10, (i == 3) ? 5 : 0);
        end
        wait_done(200, "cont_done");
        cfg_abort = 1'b0;
        tick(20);
        check("cont_entries", hs_cnt - base_hs, 4);
        check("cont_arms", arm_rise_cnt - base_arm, 4);
        check("cont_sb_empty", sb_q.size(), 0);

        // Abort while waiting for busy: no entry.
        base_hs = hs_cnt;
        start_run(16'd0, 16'd0);
        wait_arm(1'b1, 20, "ws_abort_arm");
        tick(2);
        cfg_abort = 1'b1;
        wait_done(20, "ws_abort_done");
        cfg_abort = 1'b0;
        check("ws_abort_entries", hs_cnt - base_hs, 0);
        check("ws_abort_arm_low", tdc_arm, 1'b0);

        // Start together with abort in IDLE is ignored.
        cfg_abort = 1'b1; cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0;
        tick(2);
        check("start_abort_idle", run_active, 1'b0);
        cfg_abort = 1'b0;

        // Mixed run feeding the statistics.
        start_run(16'd4, 16'd30);
        for (int i = 3; i < 7; i++) begin
            push_exp(tbl[i].exp_to ? 32'd0 : tbl[i].coarse, tbl[i].exp_to ? 9'd0 : tbl[i].fine,
                     tbl[i].exp_to, CNT_W'(i - 3));
            run_measure(tbl[i].coarse, tbl[i].fine, tbl[i].busy_len, 0);
        end
        wait_done(200, "stats_done");
        check("stats_sb_empty", sb_q.size(), 0);
`ifdef TDC_SEQ_STATS_EN
        check("stat_min", stat_min_coarse, 32'd3);
        check("stat_max", stat_max_coarse, 32'd12);
        check("stat_timeouts", stat_timeouts, 16'd1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
